// File: rtl/risc_bus_pkg.sv
// rtl/risc_bus_pkg.sv - shared types and defaults for the RISC data bus
//
// Purpose: state encoding, data width and default geometry shared by the
// data-memory responder, the core side and the benches.
// Ports: none (package).

package risc_bus_pkg;

  localparam int DATA_W              = 16;
  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_ADDR_W      = 16;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  // Full-width range check: an address equal to or above depth is an error,
  // never folded back onto a low word.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_bus_responder_if.sv
// rtl/dmem_bus_responder_if.sv - request/response handshake bundle for the data bus
//
// Purpose: groups the request and response channels of the data bus.
// Signals:
//   req_valid/req_ready  request handshake (master -> slave)
//   req_we/addr/wdata    request payload
//   rsp_valid/rsp_ready  response handshake (slave -> master)
//   rsp_rdata/rsp_err    response payload
// Modports: master (load/store unit side), slave (memory responder side).

interface dmem_bus_responder_if
  import risc_bus_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 16 word storage for the data-memory responder
//
// Purpose: word array with synchronous write, combinational read and
// asynchronous clear.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high clear of every word
//   we     in  write enable
//   addr   in  word index (shared by read and write)
//   wdata  in  write data
//   rdata  out combinational read data (0 for an index beyond DEPTH-1)

module dmem_array
  import risc_bus_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              addr_ok;

  // Guards non-power-of-two depths where the index can name a missing word.
  assign addr_ok = {1'b0, addr} < DEPTH_X;

  always_comb begin
    mem_d = mem_q;
    if (we && addr_ok) begin
      mem_d[addr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = addr_ok ? mem_q[addr] : '0;

endmodule

// File: rtl/dmem_bus_responder.sv
// rtl/dmem_bus_responder.sv - data-bus memory responder with programmable wait states
//
// Purpose: accepts one read/write at a time, waits WAIT_CYCLES cycles,
// commits the access to dmem_array and returns data or an error.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of dmem_bus_responder_if (request and response channels)

module dmem_bus_responder
  import risc_bus_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
)(
  input  logic                 clk,
  input  logic                 rst,
  dmem_bus_responder_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_ready;
  logic              rsp_valid;
  logic              commit;

  // Access being committed: with zero wait states the commit happens on the
  // accept edge itself, so the live request is used instead of the latch.
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
  end

  assign in_range = addr_in_range(32'(acc_addr), DEPTH);
  assign arr_we   = commit && acc_we && in_range;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .addr  (acc_addr[IDX_W-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    commit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Response registers only change on the commit edge, so they hold
    // steady under backpressure.
    if (commit) begin
      err_d   = !in_range;
      rdata_d = (!acc_we && in_range) ? arr_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/dmem_bus_responder.md
# dmem_bus_responder

Memory-side responder for the 16-bit RISC processor's data bus. It accepts one read or write request at a time over a valid/ready handshake, then inserts a programmable number of wait states. It commits the access to an internal word array and returns read data or an error over a second valid/ready handshake. It sits between the processor core's load/store unit and the data storage, and lets the core be exercised against non-zero memory latency.

## Interface
- DEPTH, 8: number of 16-bit words; legal 2..256.
- ADDR_W, 16: request address width.
- WAIT_CYCLES, 2: wait states between acceptance and commit; legal 0..15.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  16  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range (req_addr >= DEPTH).

## Operation
- State machine states:
  - IDLE: req_ready=1.
  - WAIT: count down.
  - RESP: rsp_valid=1.
- Transitions:
  - IDLE → WAIT on accept (req_valid & req_ready) when WAIT_CYCLES > 0.
  - IDLE → RESP directly on accept when WAIT_CYCLES = 0.
  - WAIT → RESP when the counter reaches 0.
  - RESP → IDLE on rsp_valid & rsp_ready.
- On accept, latch we, addr and wdata; later req_* changes are ignored. Load the counter with WAIT_CYCLES-1.
- Commit on the edge that enters RESP:
  - Write, in range: mem[addr] ← wdata; rsp_rdata=0; rsp_err=0.
  - Read, in range: rsp_rdata ← mem[addr]; rsp_err=0.
  - Out of range, either kind: no array update; rsp_rdata=0; rsp_err=1.
- Range check uses the full ADDR_W bits. No aliasing: address DEPTH is an error, not word 0.
- Response fields stay stable while rsp_valid=1 and rsp_ready=0.
- req_ready=0 in WAIT and RESP. A request presented then is neither accepted nor lost; it waits for IDLE.
- No back-to-back overlap: the earliest next accept is the cycle after the response handshake.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, counter 0, all array words 0.
- Accept edge at cycle N → rsp_valid high from cycle N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: rsp_valid high at N+1.
  - WAIT_CYCLES=2: rsp_valid high at N+3.
- Response handshake at edge M → req_ready high at M+1.
- With rsp_ready held high, a read costs WAIT_CYCLES+2 cycles per transaction.
- A write is visible to a read accepted on any later cycle; there is no bypass path needed, because accesses never overlap.
- Reset asserted mid-WAIT or mid-RESP:
  - Outputs go to reset values immediately (asynchronous).
  - The in-flight access is dropped. A write that has not reached RESP is never committed.
- Reset deassertion: the first accept is possible on the first rising edge with rst low.

## Structure
- Shared package risc_bus_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - DATA_W=16;
  - default DEPTH and WAIT_CYCLES, so the core and benches agree.
- One sub-module, dmem_array: DEPTH×16 storage with synchronous write, combinational read and asynchronous clear on rst.
- The FSM, counter and response registers live in dmem_bus_responder.

## Test plan
- Reset/idle: assert rst for 3 cycles, release → req_ready=1, rsp_valid=0; a read of addr 5 returns rsp_rdata=0x0000, rsp_err=0.
- Write then read, WAIT_CYCLES=2:
  - Write 0xBEEF to addr 3, then read addr 3 → rdata 0xBEEF.
  - Each rsp_valid rises exactly 3 cycles after its accept edge.
- Backpressure: hold rsp_ready=0 for 5 cycles on a read of addr 3 → rsp_valid, rdata=0xBEEF and err stay constant; req_ready stays 0; a second req_valid pulse in that window is not accepted.
- Out of range, DEPTH=8:
  - Write 0x1234 to addr 8 → rsp_err=1.
  - A following read of addr 0 returns its prior value (no aliasing); a read of addr 0xFFFF → err=1, rdata=0.
- Zero latency, WAIT_CYCLES=0, rsp_ready tied high: 4 reads of addr 0..3 → each rsp_valid 1 cycle after accept; one transaction per 2 cycles.
- Reset mid-operation: accept a write of 0xAAAA to addr 1, then assert rst during WAIT → outputs reset at once; after release, a read of addr 1 returns 0x0000.
